ccc_clken_gen: RTL

CCC_CLKEN_GEN -- requirements
Module: ccc_clken_gen

---
 rtl/ccc_pkg.sv | 23 ++
 rtl/ccc_clken_ch.sv | 64 ++++++
 rtl/ccc_clken_gen.sv | 98 +++++++++
 3 files changed

// File: rtl/ccc_pkg.sv
`default_nettype none
// ============================================================================
// Module : ccc_pkg
// Brief  : Shared types and helpers for the CCC clock-enable generator.
// Rev    : 1.0
// ============================================================================
package ccc_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  localparam int SYNC_DEPTH = 2;

  // LSB of channel ch inside the packed divide-ratio bus
  function automatic int div_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccc_clken_ch.sv
`default_nettype none
// ============================================================================
// Module : ccc_clken_ch
// Brief  : One clock-enable channel: divide counter, shadow/active ratio, CE.
// Rev    : 1.0
// ============================================================================
module ccc_clken_ch #(
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_ch_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_div_load,
  output logic             o_ce
);

  localparam logic [DIV_W-1:0] RATIO_RST = DIV_W'(DIV_INIT);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] div_last;
  logic             ce_q, ce_d;
  logic             run;
  logic             wrap;

  always_comb begin
    run      = i_run & i_ch_en;
    // ratios 0 and 1 both wrap every cycle
    div_last = (active_q == '0) ? '0 : active_q - DIV_W'(1);
    wrap     = (cnt_q == div_last);
    shadow_d = i_div_load ? i_div : shadow_q;
    cnt_d    = '0;
    ce_d     = 1'b0;
    active_d = shadow_q;
    if (run) begin
      ce_d     = wrap;
      cnt_d    = wrap ? '0 : cnt_q + DIV_W'(1);
      // a running channel only adopts a new ratio on a period boundary
      active_d = wrap ? shadow_q : active_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= RATIO_RST;
      shadow_q <= RATIO_RST;
      ce_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      ce_q     <= ce_d;
    end
  end

  assign o_ce = ce_q;

endmodule
`default_nettype wire

// File: rtl/ccc_clken_gen.sv
`default_nettype none
// ============================================================================
// Module : ccc_clken_gen
// Brief  : PLL lock qualifier, downstream reset and phase-aligned clock enables.
// Rev    : 1.0
// ============================================================================
module ccc_clken_gen #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 16,
  parameter int LOCK_FILT = 64,
  parameter int DIV_INIT  = 1
) (
  input  logic                    CLK0,
  input  logic                    RESET_N,
  input  logic                    LOCK_IN,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  input  logic                    DIV_LOAD,
  input  logic [NUM_CH-1:0]       CH_EN,
  output logic                    LOCK,
  output logic                    RESET_OUT_N,
  output logic [NUM_CH-1:0]       CE
);

  import ccc_pkg::*;

  localparam int                FILT_W    = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  lock_state_e           state_q, state_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic                  lock_q, lock_d;
  logic                  rst_out_q, rst_out_d;
  logic                  lock_s;
  logic                  run_all;

  assign lock_s = sync_q[SYNC_DEPTH-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_DEPTH-2:0], LOCK_IN};
    state_d   = state_q;
    filt_d    = '0;
    case (state_q)
      ST_UNLOCKED: begin
        if (lock_s) state_d = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!lock_s)                 state_d = ST_UNLOCKED;
        else if (filt_q == FILT_LAST) state_d = ST_LOCKED;
        else                         filt_d  = filt_q + FILT_W'(1);
      end
      ST_LOCKED: begin
        if (!lock_s) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
    lock_d    = (state_q == ST_LOCKED);
    rst_out_d = lock_q;
    // lock_d is next cycle's LOCK: channels stop on the edge LOCK falls
    run_all   = lock_q & lock_d;
  end

  always_ff @(posedge CLK0 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q    <= '0;
      state_q   <= ST_UNLOCKED;
      filt_q    <= '0;
      lock_q    <= 1'b0;
      rst_out_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      filt_q    <= filt_d;
      lock_q    <= lock_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign LOCK        = lock_q;
  assign RESET_OUT_N = rst_out_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ccc_clken_ch #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .clk        (CLK0),
      .rst_n      (RESET_N),
      .i_run      (run_all),
      .i_ch_en    (CH_EN[g]),
      .i_div      (DIV[div_lsb(g, DIV_W) +: DIV_W]),
      .i_div_load (DIV_LOAD),
      .o_ce       (CE[g])
    );
  end

endmodule
`default_nettype wire
